// File: rtl/control_unit_pkg.sv
// Shared constants for the multicycle MIPS control unit: state indices, one-hot
// state codes, opcode/funct encodings and datapath select codes.
package control_unit_pkg;

  localparam int NUM_STATES = 12;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_LBRD    = 4'd3,
    S_LBWR    = 4'd4,
    S_SBWR    = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWR = 4'd7,
    S_BEQEX   = 4'd8,
    S_JEX     = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWR  = 4'd11
  } state_idx_e;

  localparam logic [NUM_STATES-1:0] ONEHOT_FETCH   = NUM_STATES'(1) << S_FETCH;
  localparam logic [NUM_STATES-1:0] ONEHOT_DECODE  = NUM_STATES'(1) << S_DECODE;
  localparam logic [NUM_STATES-1:0] ONEHOT_MEMADR  = NUM_STATES'(1) << S_MEMADR;
  localparam logic [NUM_STATES-1:0] ONEHOT_LBRD    = NUM_STATES'(1) << S_LBRD;
  localparam logic [NUM_STATES-1:0] ONEHOT_LBWR    = NUM_STATES'(1) << S_LBWR;
  localparam logic [NUM_STATES-1:0] ONEHOT_SBWR    = NUM_STATES'(1) << S_SBWR;
  localparam logic [NUM_STATES-1:0] ONEHOT_RTYPEEX = NUM_STATES'(1) << S_RTYPEEX;
  localparam logic [NUM_STATES-1:0] ONEHOT_RTYPEWR = NUM_STATES'(1) << S_RTYPEWR;
  localparam logic [NUM_STATES-1:0] ONEHOT_BEQEX   = NUM_STATES'(1) << S_BEQEX;
  localparam logic [NUM_STATES-1:0] ONEHOT_JEX     = NUM_STATES'(1) << S_JEX;
  localparam logic [NUM_STATES-1:0] ONEHOT_ADDIEX  = NUM_STATES'(1) << S_ADDIEX;
  localparam logic [NUM_STATES-1:0] ONEHOT_ADDIWR  = NUM_STATES'(1) << S_ADDIWR;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  // Width of the fetch byte index; a single-byte fetch still gets one bit.
  function automatic int fb_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/control_unit_aludec.sv
// R-type funct decoder: maps Funct to an ALU operation and flags unknown codes.
module control_unit_aludec
  import control_unit_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucont,
  output logic       illegal
);

  always_comb begin
    alucont = ALU_ADD;
    illegal = 1'b0;
    case (funct)
      FN_ADD:  alucont = ALU_ADD;
      FN_SUB:  alucont = ALU_SUB;
      FN_AND:  alucont = ALU_AND;
      FN_OR:   alucont = ALU_OR;
      FN_SLT:  alucont = ALU_SLT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit_mc.sv
// Multicycle MIPS control unit: one-hot state register, byte-serial fetch,
// memory handshake stalls, illegal-instruction and one-hot corruption detection.
module control_unit_mc
  import control_unit_pkg::*;
#(
  parameter int IR_BYTES      = 4,
  parameter bit MEM_HANDSHAKE = 1'b1,
  localparam int FB_W         = fb_width(IR_BYTES)
) (
  input  logic                  Fclk,
  input  logic                  ResetBar,
  input  logic [5:0]            Op,
  input  logic [5:0]            Funct,
  input  logic                  Zero,
  input  logic                  mem_ready,
  output logic [NUM_STATES-1:0] S,
  output logic [FB_W-1:0]       fetch_byte,
  output logic                  mem_req,
  output logic                  MemWrite,
  output logic                  IorD,
  output logic [IR_BYTES-1:0]   IRWrite,
  output logic                  PCWrite,
  output logic                  PCWriteCond,
  output logic                  PC_En,
  output logic [1:0]            PCSrc,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [2:0]            ALUCont,
  output logic                  RegWrite,
  output logic                  RegDst,
  output logic                  MemtoReg,
  output logic                  illegal_op,
  output logic                  state_err
);

  logic [NUM_STATES-1:0] s_q, s_d;
  logic [FB_W-1:0]       fb_q, fb_d;
  logic                  done;
  logic [2:0]            fn_alu;
  logic                  fn_illegal;

  // Raw strobes before reset gating.
  logic                req, mw, pcw, pcwc, regw, ill, err;
  logic [IR_BYTES-1:0] irw;

  assign done = mem_ready | (MEM_HANDSHAKE == 1'b0);

  control_unit_aludec u_aludec (
    .funct   (Funct),
    .alucont (fn_alu),
    .illegal (fn_illegal)
  );

  always_ff @(posedge Fclk or negedge ResetBar) begin
    if (!ResetBar) begin
      s_q  <= ONEHOT_FETCH;
      fb_q <= '0;
    end else begin
      s_q  <= s_d;
      fb_q <= fb_d;
    end
  end

  always_comb begin
    s_d      = s_q;
    fb_d     = fb_q;
    req      = 1'b0;
    mw       = 1'b0;
    irw      = '0;
    pcw      = 1'b0;
    pcwc     = 1'b0;
    regw     = 1'b0;
    ill      = 1'b0;
    err      = 1'b0;
    IorD     = 1'b0;
    PCSrc    = PCSRC_ALU;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_B;
    ALUCont  = ALU_AND;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    if (!$onehot(s_q)) begin
      err  = 1'b1;
      s_d  = ONEHOT_FETCH;
      fb_d = '0;
    end else begin
      case (1'b1)
        s_q[S_FETCH]: begin
          req     = 1'b1;
          ALUSrcB = SRCB_ONE;
          ALUCont = ALU_ADD;
          PCSrc   = PCSRC_ALU;
          if (done) begin
            irw = IR_BYTES'(1) << fb_q;
            pcw = 1'b1;
            if (fb_q == FB_W'(IR_BYTES - 1)) begin
              s_d  = ONEHOT_DECODE;
              fb_d = '0;
            end else begin
              fb_d = fb_q + FB_W'(1);
            end
          end
        end
        s_q[S_DECODE]: begin
          ALUSrcB = SRCB_SHIMM;
          ALUCont = ALU_ADD;
          case (Op)
            OP_RTYPE:     s_d = ONEHOT_RTYPEEX;
            OP_LB, OP_SB: s_d = ONEHOT_MEMADR;
            OP_BEQ:       s_d = ONEHOT_BEQEX;
            OP_J:         s_d = ONEHOT_JEX;
            OP_ADDI:      s_d = ONEHOT_ADDIEX;
            default: begin
              ill = 1'b1;
              s_d = ONEHOT_FETCH;
            end
          endcase
        end
        s_q[S_MEMADR]: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          ALUCont = ALU_ADD;
          s_d     = (Op == OP_LB) ? ONEHOT_LBRD : ONEHOT_SBWR;
        end
        s_q[S_LBRD]: begin
          req  = 1'b1;
          IorD = 1'b1;
          if (done) s_d = ONEHOT_LBWR;
        end
        s_q[S_LBWR]: begin
          regw     = 1'b1;
          MemtoReg = 1'b1;
          s_d      = ONEHOT_FETCH;
        end
        s_q[S_SBWR]: begin
          req  = 1'b1;
          IorD = 1'b1;
          mw   = done;
          if (done) s_d = ONEHOT_FETCH;
        end
        s_q[S_RTYPEEX]: begin
          ALUSrcA = 1'b1;
          ALUCont = fn_alu;
          ill     = fn_illegal;
          s_d     = fn_illegal ? ONEHOT_FETCH : ONEHOT_RTYPEWR;
        end
        s_q[S_RTYPEWR]: begin
          regw   = 1'b1;
          RegDst = 1'b1;
          s_d    = ONEHOT_FETCH;
        end
        s_q[S_BEQEX]: begin
          ALUSrcA = 1'b1;
          ALUCont = ALU_SUB;
          pcwc    = 1'b1;
          PCSrc   = PCSRC_ALUOUT;
          s_d     = ONEHOT_FETCH;
        end
        s_q[S_JEX]: begin
          pcw   = 1'b1;
          PCSrc = PCSRC_JUMP;
          s_d   = ONEHOT_FETCH;
        end
        s_q[S_ADDIEX]: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          ALUCont = ALU_ADD;
          s_d     = ONEHOT_ADDIWR;
        end
        s_q[S_ADDIWR]: begin
          regw = 1'b1;
          s_d  = ONEHOT_FETCH;
        end
        default: s_d = ONEHOT_FETCH;
      endcase
    end
  end

  // Strobes are gated by the reset pin itself so they drop the instant reset asserts.
  assign S           = s_q;
  assign fetch_byte  = fb_q;
  assign mem_req     = ResetBar & req;
  assign MemWrite    = ResetBar & mw;
  assign IRWrite     = irw & {IR_BYTES{ResetBar}};
  assign PCWrite     = ResetBar & pcw;
  assign PCWriteCond = ResetBar & pcwc;
  assign PC_En       = ResetBar & (pcw | (pcwc & Zero));
  assign RegWrite    = ResetBar & regw;
  assign illegal_op  = ResetBar & ill;
  assign state_err   = ResetBar & err;

endmodule

// File: tb/tb_control_unit_mc.sv
// Bench for control_unit_mc: directed and random instruction streams checked
// cycle by cycle against an instruction-level reference model.
module tb_control_unit_mc;
  import control_unit_pkg::*;

  localparam int IR_BYTES = 4;

  logic        clk = 1'b0;
  logic        ResetBar;
  logic [5:0]  Op, Funct;
  logic        Zero, mem_ready;
  logic [11:0] S;
  logic [1:0]  fetch_byte;
  logic        mem_req, MemWrite, IorD, PCWrite, PCWriteCond, PC_En;
  logic [3:0]  IRWrite;
  logic [1:0]  PCSrc, ALUSrcB;
  logic        ALUSrcA, RegWrite, RegDst, MemtoReg, illegal_op, state_err;
  logic [2:0]  ALUCont;

  control_unit_mc #(.IR_BYTES(IR_BYTES), .MEM_HANDSHAKE(1'b1)) dut (
    .Fclk(clk), .ResetBar(ResetBar), .Op(Op), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .S(S), .fetch_byte(fetch_byte), .mem_req(mem_req),
    .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .PC_En(PC_En), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUCont(ALUCont), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .illegal_op(illegal_op), .state_err(state_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] s;
    logic [1:0]  fb;
    logic        mem_req, mem_write, iord;
    logic [3:0]  irw;
    logic        pcw, pcwc, pc_en;
    logic [1:0]  pcsrc;
    logic        srca;
    logic [1:0]  srcb;
    logic [2:0]  alu;
    logic        regw, regdst, memtoreg, ill, err;
  } obs_t;

  typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_LBRD, P_LBWR, P_SBWR, P_RTYPEEX,
                P_RTYPEWR, P_BEQEX, P_JEX, P_ADDIEX, P_ADDIWR} ph_e;

  obs_t       obs;
  ph_e        ph;
  logic [1:0] fb;
  int         n_assert = 0;
  int         n_fail   = 0;

  always_comb begin
    obs = '{s: S, fb: fetch_byte, mem_req: mem_req, mem_write: MemWrite, iord: IorD,
            irw: IRWrite, pcw: PCWrite, pcwc: PCWriteCond, pc_en: PC_En, pcsrc: PCSrc,
            srca: ALUSrcA, srcb: ALUSrcB, alu: ALUCont, regw: RegWrite, regdst: RegDst,
            memtoreg: MemtoReg, ill: illegal_op, err: state_err};
  end

  function automatic logic [11:0] onehot_of(input ph_e p);
    case (p)
      P_FETCH:   return ONEHOT_FETCH;
      P_DECODE:  return ONEHOT_DECODE;
      P_MEMADR:  return ONEHOT_MEMADR;
      P_LBRD:    return ONEHOT_LBRD;
      P_LBWR:    return ONEHOT_LBWR;
      P_SBWR:    return ONEHOT_SBWR;
      P_RTYPEEX: return ONEHOT_RTYPEEX;
      P_RTYPEWR: return ONEHOT_RTYPEWR;
      P_BEQEX:   return ONEHOT_BEQEX;
      P_JEX:     return ONEHOT_JEX;
      P_ADDIEX:  return ONEHOT_ADDIEX;
      default:   return ONEHOT_ADDIWR;
    endcase
  endfunction

  // {illegal, alu code} for an R-type funct field, straight from the ISA table.
  function automatic logic [3:0] funct_info(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b0_010;
      6'b100010: return 4'b0_110;
      6'b100100: return 4'b0_000;
      6'b100101: return 4'b0_001;
      6'b101010: return 4'b0_111;
      default:   return 4'b1_010;
    endcase
  endfunction

  function automatic bit op_known(input logic [5:0] op);
    return op inside {6'b000000, 6'b100000, 6'b101000, 6'b000100, 6'b000010, 6'b001000};
  endfunction

  function automatic obs_t model_out(input ph_e p, input logic [1:0] f, input logic [5:0] op,
                                     input logic [5:0] fn, input logic z, input logic rdy);
    obs_t e;
    logic [3:0] fi;
    e = '0;
    e.s  = onehot_of(p);
    e.fb = f;
    fi   = funct_info(fn);
    case (p)
      P_FETCH: begin
        e.mem_req = 1'b1; e.srcb = 2'b01; e.alu = 3'b010;
        if (rdy) begin e.irw = 4'b0001 << f; e.pcw = 1'b1; end
      end
      P_DECODE:  begin e.srcb = 2'b11; e.alu = 3'b010; e.ill = !op_known(op); end
      P_MEMADR, P_ADDIEX: begin e.srca = 1'b1; e.srcb = 2'b10; e.alu = 3'b010; end
      P_LBRD:    begin e.mem_req = 1'b1; e.iord = 1'b1; end
      P_LBWR:    begin e.regw = 1'b1; e.memtoreg = 1'b1; end
      P_SBWR:    begin e.mem_req = 1'b1; e.iord = 1'b1; e.mem_write = rdy; end
      P_RTYPEEX: begin e.srca = 1'b1; e.alu = fi[2:0]; e.ill = fi[3]; end
      P_RTYPEWR: begin e.regw = 1'b1; e.regdst = 1'b1; end
      P_BEQEX:   begin e.srca = 1'b1; e.alu = 3'b110; e.pcwc = 1'b1; e.pcsrc = 2'b01; end
      P_JEX:     begin e.pcw = 1'b1; e.pcsrc = 2'b10; end
      default:   e.regw = 1'b1;
    endcase
    e.pc_en = e.pcw | (e.pcwc & z);
    return e;
  endfunction

  function automatic obs_t reset_out();
    obs_t e;
    e = model_out(P_FETCH, 2'd0, 6'd0, 6'd0, 1'b0, 1'b1);
    e.mem_req = 0; e.mem_write = 0; e.irw = '0; e.pcw = 0; e.pcwc = 0;
    e.pc_en = 0; e.regw = 0; e.ill = 0; e.err = 0;
    return e;
  endfunction

  task automatic advance(input logic [5:0] op, input logic [5:0] fn, input logic rdy);
    logic [3:0] fi;
    fi = funct_info(fn);
    case (ph)
      P_FETCH: if (rdy) begin
        if (fb == 2'(IR_BYTES - 1)) begin ph = P_DECODE; fb = 2'd0; end
        else fb = fb + 2'd1;
      end
      P_DECODE: case (op)
        6'b000000: ph = P_RTYPEEX;
        6'b100000, 6'b101000: ph = P_MEMADR;
        6'b000100: ph = P_BEQEX;
        6'b000010: ph = P_JEX;
        6'b001000: ph = P_ADDIEX;
        default:   ph = P_FETCH;
      endcase
      P_MEMADR:  ph = (op == 6'b100000) ? P_LBRD : P_SBWR;
      P_LBRD:    if (rdy) ph = P_LBWR;
      P_SBWR:    if (rdy) ph = P_FETCH;
      P_RTYPEEX: ph = fi[3] ? P_FETCH : P_RTYPEWR;
      P_ADDIEX:  ph = P_ADDIWR;
      default:   ph = P_FETCH;
    endcase
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs (X where the current state must not look), check, advance model.
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic rdy, input string tag);
    obs_t e;
    @(negedge clk);
    Op        = (ph == P_DECODE || ph == P_MEMADR) ? op : 6'bx;
    Funct     = (ph == P_RTYPEEX) ? fn : 6'bx;
    Zero      = (ph == P_BEQEX) ? z : 1'bx;
    mem_ready = (ph == P_FETCH || ph == P_LBRD || ph == P_SBWR) ? rdy : 1'bx;
    #1;
    e = model_out(ph, fb, op, fn, z, rdy);
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h in %s", tag, obs, e, ph.name());
    end
    advance(op, fn, rdy);
  endtask

  // Full instruction from FETCH back to FETCH, with stalls on the first fetch byte and memory.
  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fstall, input int mstall, input string tag);
    int fs, ms, guard;
    bit left;
    fs = fstall; ms = mstall; guard = 0; left = 0;
    do begin
      logic rdy;
      rdy = 1'b1;
      if (ph == P_FETCH && fs > 0) begin rdy = 1'b0; fs--; end
      else if ((ph == P_LBRD || ph == P_SBWR) && ms > 0) begin rdy = 1'b0; ms--; end
      if (ph != P_FETCH) left = 1;
      step(op, fn, z, rdy, tag);
      guard++;
    end while (!(left && ph == P_FETCH) && guard < 60);
    chk({tag, "_bound"}, 64'(guard < 60), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] rop, rfn;
    ResetBar = 1'b1; Op = 6'd0; Funct = 6'd0; Zero = 1'b0; mem_ready = 1'b1;
    ph = P_FETCH; fb = 2'd0;
    #3 ResetBar = 1'b0;

    // Reset: FETCH state, strobes held low even with mem_ready high.
    repeat (2) begin
      @(negedge clk); #1;
      chk("reset_out", 64'(obs), 64'(reset_out()));
    end
    @(posedge clk); #1 ResetBar = 1'b1;

    // Four fetch bytes, then DECODE on cycle 5 (jump instruction).
    for (int i = 0; i < 4; i++) begin
      step(6'b000010, 6'd0, 1'b0, 1'b1, "fetch");
      chk("fetch_irw", 64'(IRWrite), 64'(4'b0001 << i));
      chk("fetch_pcw", 64'(PCWrite), 64'd1);
    end
    step(6'b000010, 6'd0, 1'b0, 1'b1, "decode_j");
    chk("decode_reached", 64'(S), 64'(ONEHOT_DECODE));
    step(6'b000010, 6'd0, 1'b0, 1'b1, "jex");
    chk("jex_pcen", 64'(PC_En), 64'd1);

    // Fetch stalled 3 cycles, then lb with LBRD stalled 2 cycles.
    instr(6'b100000, 6'd0, 1'b0, 3, 2, "lb_stall");
    // beq taken then not taken.
    instr(6'b000100, 6'd0, 1'b1, 0, 0, "beq_z1");
    instr(6'b000100, 6'd0, 1'b0, 0, 0, "beq_z0");
    // Illegal opcode, illegal funct, then each legal form.
    instr(6'b111111, 6'd0, 1'b0, 0, 0, "bad_op");
    instr(6'b000000, 6'b000111, 1'b0, 0, 0, "bad_funct");
    instr(6'b000000, 6'b100010, 1'b0, 0, 0, "rtype_sub");
    instr(6'b000000, 6'b101010, 1'b0, 0, 0, "rtype_slt");
    instr(6'b001000, 6'd0, 1'b0, 1, 0, "addi");
    instr(6'b101000, 6'd0, 1'b0, 0, 2, "sb_stall");

    // Random instruction stream.
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 7))
        0: rop = 6'b000000;
        1: rop = 6'b100000;
        2: rop = 6'b101000;
        3: rop = 6'b000100;
        4: rop = 6'b000010;
        5: rop = 6'b001000;
        6: rop = 6'b000000;
        default: rop = 6'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: rfn = 6'b100000;
        1: rfn = 6'b100010;
        2: rfn = 6'b100100;
        3: rfn = 6'b100101;
        4: rfn = 6'b101010;
        default: rfn = 6'($urandom);
      endcase
      instr(rop, rfn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), "random");
    end

    // Corrupt the state register while in JEX: error flagged, strobes suppressed, then FETCH.
    for (int i = 0; i < 4; i++) step(6'b000010, 6'd0, 1'b0, 1'b1, "pre_force");
    step(6'b000010, 6'd0, 1'b0, 1'b1, "pre_force_dec");
    @(negedge clk);
    Op = 6'd0; Funct = 6'd0; Zero = 1'b1; mem_ready = 1'b1;
    force dut.s_q = '0;
    #1;
    chk("err_flag", 64'(state_err), 64'd1);
    chk("err_strobes", 64'({mem_req, MemWrite, IRWrite, PCWrite, PCWriteCond, PC_En,
                            RegWrite, illegal_op}), 64'd0);
    release dut.s_q;
    @(posedge clk); #1;
    chk("err_recover_s", 64'(S), 64'(ONEHOT_FETCH));
    chk("err_recover_fb", 64'({state_err, fetch_byte}), 64'd0);
    ph = P_FETCH; fb = 2'd0;

    // Reset asserted in SBWR while the store is completing.
    for (int i = 0; i < 4; i++) step(6'b101000, 6'd0, 1'b0, 1'b1, "sb_fetch");
    step(6'b101000, 6'd0, 1'b0, 1'b1, "sb_decode");
    step(6'b101000, 6'd0, 1'b0, 1'b1, "sb_memadr");
    step(6'b101000, 6'd0, 1'b0, 1'b0, "sb_wait");
    @(negedge clk);
    mem_ready = 1'b1; Op = 6'bx;
    #1;
    chk("sb_memwrite", 64'(MemWrite), 64'd1);
    #1 ResetBar = 1'b0;
    #1;
    chk("rst_memwrite", 64'({MemWrite, mem_req}), 64'd0);
    chk("rst_state", 64'({S, fetch_byte}), 64'({ONEHOT_FETCH, 2'd0}));
    ph = P_FETCH; fb = 2'd0;
    @(posedge clk); #1 ResetBar = 1'b1;
    instr(6'b001000, 6'd0, 1'b0, 0, 0, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
